// File: rtl/tc_switch_pkg.sv
// Shared types and constants for the round-robin tri-state switch replacement.
package tc_switch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    LOCKED  = 2'd2
  } tc_sw_state_t;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic int unsigned ptr_width(input int unsigned channels);
    return $clog2(channels);
  endfunction

endpackage

// File: rtl/tc_rr_picker.sv
// Combinational round-robin picker: first set req bit searching ptr+1 .. ptr with wrap.
module tc_rr_picker
  import tc_switch_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PTR_W    = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [PTR_W-1:0]    index,
  output logic                any
);

  logic [PTR_W-1:0] k;

  always_comb begin
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    k     = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      k = PTR_W'((32'(ptr) + i) % CHANNELS);
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        index  = k;
      end
    end
  end

endmodule

// File: rtl/tc_switch_arbiter.sv
// Shared-bus switch with registered round-robin arbitration, owner lock and conflict flag.
// Optional conflict statistics counter enabled by TC_SWITCH_ARB_STATS_EN.
module tc_switch_arbiter
  import tc_switch_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       lock,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       grant,
  output logic                      conflict
`ifdef TC_SWITCH_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]          conflict_count
`endif
);

  localparam int unsigned PTR_W = ptr_width(CHANNELS);

  tc_sw_state_t          state_q, state_d;
  logic [PTR_W-1:0]      ptr_q;
  logic [CHANNELS-1:0]   pick_gnt;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  hold;
  logic                  sel_valid;
  logic [PTR_W-1:0]      sel_idx;
  logic [CHANNELS-1:0]   sel_gnt;
  logic [WIDTH-1:0]      sel_data;
  logic                  multi;

  tc_rr_picker #(
    .CHANNELS (CHANNELS),
    .PTR_W    (PTR_W)
  ) u_picker (
    .req   (en),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .index (pick_idx),
    .any   (pick_any)
  );

  // grant is the one-hot owner and ptr_q its index whenever an owner exists
  assign hold  = (state_q != IDLE) && |(grant & en & lock);
  assign multi = |(en & (en - CHANNELS'(1)));

  always_comb begin
    state_d   = state_q;
    sel_valid = 1'b0;
    sel_idx   = ptr_q;
    sel_gnt   = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = GRANTED;
          sel_valid = 1'b1;
          sel_idx   = pick_idx;
          sel_gnt   = pick_gnt;
        end
      end
      GRANTED, LOCKED: begin
        if (hold) begin
          state_d   = LOCKED;
          sel_valid = 1'b1;
          sel_gnt   = grant;
        end else if (pick_any) begin
          state_d   = GRANTED;
          sel_valid = 1'b1;
          sel_idx   = pick_idx;
          sel_gnt   = pick_gnt;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (PTR_W'(c) == sel_idx) sel_data = in[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_W'(CHANNELS - 1);
      out       <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
      conflict  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= sel_valid;
      grant     <= sel_gnt;
      out       <= sel_valid ? sel_data : '0;
      conflict  <= multi;
      if (sel_valid) ptr_q <= sel_idx;
    end
  end

`ifdef TC_SWITCH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_count <= '0;
    end else if (multi && conflict_count != CNT_MAX) begin
      conflict_count <= conflict_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tc_switch_arbiter.sv
// Directed table-driven bench for tc_switch_arbiter (CHANNELS=4, WIDTH=8).
// Stats counter checks compile in only when TC_SWITCH_ARB_STATS_EN is defined.
module tb_tc_switch_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [31:0] din;
  logic [3:0]  lock;
  logic [7:0]  out;
  logic        out_valid;
  logic [3:0]  grant;
  logic        conflict;
`ifdef TC_SWITCH_ARB_STATS_EN
  logic [15:0] conflict_count;
`endif

  int tests;
  int failed;

  tc_switch_arbiter #(
    .CHANNELS (4),
    .WIDTH    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (din),
    .lock      (lock),
    .out       (out),
    .out_valid (out_valid),
    .grant     (grant),
    .conflict  (conflict)
`ifdef TC_SWITCH_ARB_STATS_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  lock;
    logic [31:0] din;
    logic [7:0]  eout;
    logic        ev;
    logic [3:0]  eg;
    logic        ec;
  } vec_t;

  localparam logic [31:0] D = 32'h44332211;
  localparam int NV = 19;
  vec_t v [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eo, input logic ev,
                           input logic [3:0] eg, input logic ec);
    chk({tag, ".out"},      32'(out),       32'(eo));
    chk({tag, ".valid"},    32'(out_valid), 32'(ev));
    chk({tag, ".grant"},    32'(grant),     32'(eg));
    chk({tag, ".conflict"}, 32'(conflict),  32'(ec));
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b0;
    en     = 4'hF;
    lock   = 4'h0;
    din    = D;

    //        rst   en     lock   din            out    v     grant  conf
    v[0]  = '{1'b0, 4'hF, 4'h0, D,             8'h00, 1'b0, 4'h0, 1'b0};
    v[1]  = '{1'b1, 4'h0, 4'h0, D,             8'h00, 1'b0, 4'h0, 1'b0};
    v[2]  = '{1'b1, 4'h4, 4'h0, 32'h44A52211,  8'hA5, 1'b1, 4'h4, 1'b0};
    v[3]  = '{1'b1, 4'h0, 4'h0, D,             8'h00, 1'b0, 4'h0, 1'b0};
    v[4]  = '{1'b0, 4'hF, 4'h0, D,             8'h00, 1'b0, 4'h0, 1'b0};
    v[5]  = '{1'b1, 4'hF, 4'h0, D,             8'h11, 1'b1, 4'h1, 1'b1};
    v[6]  = '{1'b1, 4'hF, 4'h0, D,             8'h22, 1'b1, 4'h2, 1'b1};
    v[7]  = '{1'b1, 4'hF, 4'h0, D,             8'h33, 1'b1, 4'h4, 1'b1};
    v[8]  = '{1'b1, 4'hF, 4'h0, D,             8'h44, 1'b1, 4'h8, 1'b1};
    v[9]  = '{1'b1, 4'hF, 4'h0, D,             8'h11, 1'b1, 4'h1, 1'b1};
    v[10] = '{1'b1, 4'h3, 4'h1, D,             8'h11, 1'b1, 4'h1, 1'b1};
    v[11] = '{1'b1, 4'h3, 4'h1, D,             8'h11, 1'b1, 4'h1, 1'b1};
    v[12] = '{1'b1, 4'h3, 4'h0, D,             8'h22, 1'b1, 4'h2, 1'b1};
    v[13] = '{1'b1, 4'h8, 4'h0, D,             8'h44, 1'b1, 4'h8, 1'b0};
    v[14] = '{1'b1, 4'h9, 4'h0, D,             8'h11, 1'b1, 4'h1, 1'b1};
    v[15] = '{1'b1, 4'h9, 4'h1, D,             8'h11, 1'b1, 4'h1, 1'b1};
    v[16] = '{1'b1, 4'h8, 4'h1, D,             8'h44, 1'b1, 4'h8, 1'b0};
    v[17] = '{1'b1, 4'h9, 4'h8, D,             8'h44, 1'b1, 4'h8, 1'b1};
    v[18] = '{1'b1, 4'h9, 4'h8, 32'h5A332211,  8'h5A, 1'b1, 4'h8, 1'b1};

    #2;
    check_all("async_reset", 8'h00, 1'b0, 4'h0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst  = v[i].rst;
      en   = v[i].en;
      lock = v[i].lock;
      din  = v[i].din;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), v[i].eout, v[i].ev, v[i].eg, v[i].ec);
    end

    // Asynchronous reset asserted mid-cycle while ch3 holds the bus locked
    #2;
    rst = 1'b0;
    #1;
    check_all("midlock_reset", 8'h00, 1'b0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    check_all("reset_held", 8'h00, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    rst  = 1'b1;
    en   = 4'hF;
    lock = 4'h0;
    din  = D;
    @(posedge clk);
    #1;
    check_all("post_reset_pick", 8'h11, 1'b1, 4'h1, 1'b1);

`ifdef TC_SWITCH_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stats_reset", 32'(conflict_count), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    en  = 4'hF;
    @(posedge clk);
    #1;
    chk("stats_first", 32'(conflict_count), 32'h1);
    repeat (69999) @(posedge clk);
    #1;
    chk("stats_saturate", 32'(conflict_count), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
